// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings and sizing helpers.
package fifo_pkg;

    typedef enum logic {
        FWFT_REGISTERED = 1'b0,
        FWFT_FALLTHRU   = 1'b1
    } fwft_mode_e;

    localparam int FWFT_MODE_REG  = 0;
    localparam int FWFT_MODE_FALL = 1;

    function automatic int fifo_depth(input int size);
        return 2 ** size;
    endfunction

    function automatic int fifo_cnt_w(input int size);
        return size + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, combinational read.
module fifo_ram #(
    parameter int BITS = 8,
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [SIZE-1:0] i_waddr,
    input  logic [BITS-1:0] i_wdata,
    input  logic [SIZE-1:0] i_raddr,
    output logic [BITS-1:0] o_rdata
);

    logic [BITS-1:0] r_mem [2**SIZE];

    // NOTE: storage has no reset; the control logic alone decides which words are valid.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_lvl.sv
// Synchronous FIFO with level flags, sticky error flags, flush and selectable FWFT read.
module fifo_sync_lvl
    import fifo_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int SIZE       = 4,
    parameter int AFULL_LVL  = 2**SIZE - 2,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = FWFT_MODE_REG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] wdata,
    input  logic            wr,
    input  logic            rd,
    input  logic            flush,
    input  logic            clr_err,
    output logic [BITS-1:0] rdata,
    output logic            rvalid,
    output logic            full,
    output logic            empty,
    output logic            afull,
    output logic            aempty,
    output logic [SIZE:0]   count,
    output logic            overflow,
    output logic            underflow
);

    localparam int DEPTH = fifo_depth(SIZE);
    localparam int CNT_W = fifo_cnt_w(SIZE);

    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AFULL  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] C_AEMPTY = CNT_W'(AEMPTY_LVL);

    logic [SIZE-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_full, r_empty, r_afull, r_aempty;
    logic             r_overflow, r_underflow;
    logic             w_wr_acc, w_rd_acc;
    logic             w_ovf_evt, w_udf_evt;
    logic [BITS-1:0]  w_ram_rdata;

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        w_rd_acc    = rd && !r_empty && !flush;
        w_wr_acc    = wr && (!r_full || w_rd_acc) && !flush;
        w_ovf_evt   = wr && r_full && !w_rd_acc && !flush;
        w_udf_evt   = rd && r_empty && !flush;
        w_count_nxt = r_count;
        if (flush)
            w_count_nxt = '0;
        else if (w_wr_acc && !w_rd_acc)
            w_count_nxt = r_count + CNT_W'(1);
        else if (w_rd_acc && !w_wr_acc)
            w_count_nxt = r_count - CNT_W'(1);
    end

    // Flags are derived from the next count so they line up with count every cycle.
    // NOTE: clocked state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + SIZE'(1);
                if (w_rd_acc) r_rptr <= r_rptr + SIZE'(1);
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= C_AFULL);
            r_aempty <= (w_count_nxt <= C_AEMPTY);
        end
    end

    // A new error event wins over clr_err in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)    r_overflow  <= 1'b1;
            else if (clr_err) r_overflow  <= 1'b0;
            if (w_udf_evt)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    fifo_ram #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_rdata)
    );

    generate
        if (FWFT == FWFT_MODE_FALL) begin : g_fwft
            // Head word shown directly; forced to zero while empty so reset reads 0.
            assign rdata  = r_empty ? '0 : w_ram_rdata;
            assign rvalid = !r_empty;
        end else begin : g_reg
            logic [BITS-1:0] r_rdata;
            logic            r_rvalid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) r_rdata <= w_ram_rdata;
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate

    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign afull     = r_afull;
    assign aempty    = r_aempty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: doc/fifo_sync_lvl.md
FIFO_SYNC_LVL -- requirements
Module: fifo_sync_lvl

Interface
REQ-001 Parameter BITS, default 8, data word width in bits.
REQ-002 Parameter SIZE, default 4, address width; depth DEPTH = 2**SIZE words.
REQ-003 Parameter AFULL_LVL, default 2**SIZE-2, occupancy at or above which afull asserts.
REQ-004 Parameter AEMPTY_LVL, default 2, occupancy at or below which aempty asserts.
REQ-005 Parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 Interface SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 wdata  in  BITS  write data.
REQ-010 wr  in  1  write request.
REQ-011 rd  in  1  read request.
REQ-012 flush  in  1  synchronous clear of contents.
REQ-013 clr_err  in  1  synchronous clear of sticky error flags.
REQ-014 rdata  out  BITS  read data.
REQ-015 rvalid  out  1  rdata holds a popped word (FWFT=0) or the head word (FWFT=1).
REQ-016 full, empty, afull, aempty  out  1 each  status flags.
REQ-017 count  out  SIZE+1  current occupancy, 0..DEPTH.
REQ-018 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-019 Write is accepted when wr && (!full || read accepted in the same cycle); the word is stored at wptr, and wptr advances modulo DEPTH.
REQ-020 Read is accepted when rd && !empty; rptr advances modulo DEPTH.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged, including when full.
REQ-022 On empty, wr+rd SHALL accept the write only; underflow SHALL set and count becomes 1.
REQ-023 count SHALL update as count + accepted_wr - accepted_rd with no wrap; full = (count==DEPTH) and empty = (count==0), registered.
REQ-024 afull = (count >= AFULL_LVL) and aempty = (count <= AEMPTY_LVL), both registered and consistent with count in the same cycle.
REQ-025 FWFT=0: rdata SHALL register the word at rptr on an accepted read, valid the next cycle with rvalid=1 for that one cycle; otherwise rdata holds its value and rvalid=0.
REQ-026 FWFT=1: rdata SHALL show the word at rptr whenever !empty, with rvalid = !empty; an accepted read SHALL present the next word in the following cycle.
REQ-027 A write to an empty FIFO in FWFT=1 SHALL appear on rdata one cycle after the write edge.
REQ-028 overflow SHALL set on wr while full with no accepted read; underflow SHALL set on rd while empty; both hold until clr_err or reset.
REQ-029 clr_err and a new error event in the same cycle SHALL leave the flag set.
REQ-030 flush SHALL zero the pointers and count, set empty and aempty, clear full and afull, and clear rvalid; wr/rd in a flush cycle SHALL be ignored; memory contents are not cleared.
REQ-031 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no lost or duplicated word.

Reset
REQ-032 On !rst, immediately and asynchronously: pointers=0, count=0, empty=1, aempty=1, full=0, afull=0, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-033 Reset asserted mid-transfer SHALL discard all contents; the storage array is not reset.
REQ-034 Reset release SHALL be synchronous-safe; the first write is accepted on the first clk edge after release.

Structure
REQ-035 DEPTH and count-width localparams, plus the FWFT mode encodings, SHALL live in the shared fifo package/include used by all FIFO variants.
REQ-036 Storage SHALL be a sub-module fifo_ram: simple dual-port, synchronous write, combinational read, parameters BITS and SIZE.
REQ-037 Control (pointers, count, flags, errors) SHALL stay in fifo_sync_lvl with no latches and a single clocked process per register group.

Verification (BITS=8, SIZE=2, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-038 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; afull at count 3; full at count 4; a fifth wr with 0x55 -> overflow=1, count stays 4.
REQ-039 From full, FWFT=0, issue 4 reads -> rdata 0x11,0x22,0x33,0x44, each one cycle after its rd with rvalid=1; then empty=1; an extra rd -> underflow=1.
REQ-040 Hold full and drive wr+rd for 6 cycles -> count stays 4, no overflow, output order preserved across the pointer wrap.
REQ-041 FWFT=1, write 0xA5 into empty -> next cycle rdata=0xA5, rvalid=1; rd -> empty=1, rvalid=0.
REQ-042 With 3 words stored, pulse flush, then separately assert rst mid-burst -> count=0, empty=1, flags cleared per REQ-030/REQ-032; clr_err clears overflow/underflow.
